sepia_frame_writer: RTL and testbench



---
 rtl/sepia_frame_writer_pkg.sv | 28 ++
 rtl/sepia_frame_writer_fifo.sv | 75 +++++++
 rtl/sepia_frame_writer.sv | 193 +++++++++++++++++++
 tb/tb_sepia_frame_writer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sepia_frame_writer_pkg.sv
// Shared types and helpers for the sepia frame writer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sepia_frame_writer_pkg;

  localparam int FRAME_W_DEF = 640;
  localparam int FRAME_H_DEF = 480;
  localparam int ADDR_W_DEF  = 18;

  localparam int HALF_W = 18;          // one RGB666 pixel
  localparam int WORD_W = 2 * HALF_W;  // one memory word = two pixels

  typedef logic [HALF_W-1:0] half_t;

  // Left pixel (even x) lives in the upper half of the word.
  typedef struct packed {
    half_t hi;
    half_t lo;
  } word_t;

  // RGB888 -> RGB666 by keeping the top six bits of each channel.
  function automatic half_t pack666(input logic [7:0] r,
                                    input logic [7:0] g,
                                    input logic [7:0] b);
    return {r[7:2], g[7:2], b[7:2]};
  endfunction

endpackage

// File: rtl/sepia_frame_writer_fifo.sv
// Synchronous show-ahead FIFO holding {address, word} entries for the writer.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
//
// Ports: clk/rst_n (async active-low), push/din write side, pop read side,
//        full/empty status, head = oldest entry (valid while !empty).
module pix_word_fifo #(
  parameter int WIDTH = 54,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // When full, the write slot equals the head slot; a same-cycle pop frees it.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/sepia_frame_writer.sv
// Packs sepia-filtered pixel pairs into 36-bit words and writes them to the frame buffer.
// Latency: odd pixel presented in cycle 0 is queued at end of cycle 4; mem_req rises in cycle 5.
// Backpressure: FIFO absorbs mem_ack stalls; a word arriving at a full FIFO with no pop is dropped (overflow).
//
// Ports: clk, rst (async active-low); in_valid/in_sof/in_x/in_y alongside the
//        sepia input; pix_r/g/b from the sepia output; mem_req/mem_addr/mem_data/
//        mem_ack write port; overflow, pair_err sticky flags; frame_done pulse.
module sepia_frame_writer
  import sepia_frame_writer_pkg::*;
#(
  parameter int FILTER_LAT = 4,
  parameter int FRAME_W    = FRAME_W_DEF,
  parameter int FRAME_H    = FRAME_H_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [9:0]        in_x,
  input  logic [8:0]        in_y,
  input  logic [7:0]        pix_r,
  input  logic [7:0]        pix_g,
  input  logic [7:0]        pix_b,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              overflow,
  output logic              pair_err,
  output logic              frame_done
);

  localparam int ENTRY_W = ADDR_W + WORD_W;
  localparam logic [ADDR_W-1:0] LINE_WORDS = ADDR_W'(FRAME_W / 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_H * FRAME_W / 2 - 1);

  // Side-band delay line matching the sepia pipeline depth.
  logic       dl_vld_q [FILTER_LAT];
  logic       dl_vld_d [FILTER_LAT];
  logic       dl_sof_q [FILTER_LAT];
  logic       dl_sof_d [FILTER_LAT];
  logic [9:0] dl_x_q   [FILTER_LAT];
  logic [9:0] dl_x_d   [FILTER_LAT];
  logic [8:0] dl_y_q   [FILTER_LAT];
  logic [8:0] dl_y_d   [FILTER_LAT];

  // Pending left half-word and sticky status.
  logic              pend_vld_q, pend_vld_d;
  half_t             pend_half_q, pend_half_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              ovf_q, ovf_d;
  logic              perr_q, perr_d;
  logic              frame_done_q, frame_done_d;

  // Aligned view of the delay line (lines up with pix_*).
  logic              a_vld;
  logic              a_sof;
  logic [9:0]        a_x;
  logic [8:0]        a_y;
  logic [ADDR_W-1:0] a_addr;
  logic              a_in_range;
  half_t             new_half;
  logic              pend_live;
  logic              word_push;
  word_t             push_word;

  // FIFO side.
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0]  head_addr;

  always_comb begin
    dl_vld_d[0] = in_valid;
    dl_sof_d[0] = in_valid & in_sof;
    dl_x_d[0]   = in_x;
    dl_y_d[0]   = in_y;
    for (int i = 1; i < FILTER_LAT; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_sof_d[i] = dl_sof_q[i-1];
      dl_x_d[i]   = dl_x_q[i-1];
      dl_y_d[i]   = dl_y_q[i-1];
    end
  end

  assign a_vld      = dl_vld_q[FILTER_LAT-1];
  assign a_sof      = dl_sof_q[FILTER_LAT-1];
  assign a_x        = dl_x_q[FILTER_LAT-1];
  assign a_y        = dl_y_q[FILTER_LAT-1];
  assign a_in_range = (int'(a_x) < FRAME_W) && (int'(a_y) < FRAME_H);
  // Both pixels of a pair map to the same word address.
  assign a_addr     = ADDR_W'(a_y) * LINE_WORDS + ADDR_W'(a_x[9:1]);
  assign new_half   = pack666(pix_r, pix_g, pix_b);
  assign push_word  = '{hi: pend_half_q, lo: new_half};

  assign fifo_pop   = ~fifo_empty & mem_ack;
  assign head_addr  = fifo_head[ENTRY_W-1:WORD_W];

  always_comb begin
    pend_vld_d   = pend_vld_q;
    pend_half_d  = pend_half_q;
    pend_addr_d  = pend_addr_q;
    ovf_d        = ovf_q;
    perr_d       = perr_q;
    pend_live    = pend_vld_q;
    word_push    = 1'b0;
    frame_done_d = fifo_pop && (head_addr == LAST_ADDR);

    if (a_vld) begin
      // Start of frame wipes state first; the sof pixel is then processed normally.
      if (a_sof) begin
        pend_live = 1'b0;
        ovf_d     = 1'b0;
        perr_d    = 1'b0;
      end
      pend_vld_d = pend_live;

      if (!a_in_range) begin
        perr_d = 1'b1;
      end else if (!a_x[0]) begin
        // A new left pixel always wins; an orphaned older half is an error.
        if (pend_live) begin
          perr_d = 1'b1;
        end
        pend_vld_d  = 1'b1;
        pend_half_d = new_half;
        pend_addr_d = a_addr;
      end else if (pend_live && (pend_addr_q == a_addr)) begin
        word_push  = 1'b1;
        pend_vld_d = 1'b0;
      end else begin
        perr_d = 1'b1;
      end
    end

    if (word_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FILTER_LAT; i++) begin
        dl_vld_q[i] <= 1'b0;
        dl_sof_q[i] <= 1'b0;
        dl_x_q[i]   <= '0;
        dl_y_q[i]   <= '0;
      end
      pend_vld_q   <= 1'b0;
      pend_half_q  <= '0;
      pend_addr_q  <= '0;
      ovf_q        <= 1'b0;
      perr_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      dl_vld_q     <= dl_vld_d;
      dl_sof_q     <= dl_sof_d;
      dl_x_q       <= dl_x_d;
      dl_y_q       <= dl_y_d;
      pend_vld_q   <= pend_vld_d;
      pend_half_q  <= pend_half_d;
      pend_addr_q  <= pend_addr_d;
      ovf_q        <= ovf_d;
      perr_q       <= perr_d;
      frame_done_q <= frame_done_d;
    end
  end

  pix_word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (word_push),
    .din   ({pend_addr_q, push_word}),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign mem_req    = ~fifo_empty;
  assign mem_addr   = head_addr;
  assign mem_data   = fifo_head[WORD_W-1:0];
  assign overflow   = ovf_q;
  assign pair_err   = perr_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sepia_frame_writer.sv
// Self-checking bench for sepia_frame_writer with an identity 4-cycle filter model.
// Latency: pix_* are driven 4 cycles after the matching in_* values.
// Backpressure: mem_ack is held low, high or random per test phase.
module tb_sepia_frame_writer;

  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;
  localparam int ADDR_W  = 18;
  localparam int LAT     = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [35:0]       data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_sof;
  logic [9:0]        in_x;
  logic [8:0]        in_y;
  logic [7:0]        pix_r, pix_g, pix_b;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [35:0]       mem_data;
  logic              mem_ack;
  logic              overflow, pair_err, frame_done;

  int   checks = 0;
  int   errors = 0;
  int   pop_cnt = 0;
  int   fd_cnt = 0;
  bit   prev_last = 1'b0;
  int   ack_mode = 0;
  int   pc0;
  exp_t sb[$];
  logic [23:0] hist [LAT+1];

  sepia_frame_writer #(
    .FILTER_LAT (LAT),
    .FRAME_W    (FRAME_W),
    .FRAME_H    (FRAME_H),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_x       (in_x),
    .in_y       (in_y),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ack    (mem_ack),
    .overflow   (overflow),
    .pair_err   (pair_err),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [17:0] bpack(input logic [23:0] c);
    return {c[23:18], c[15:10], c[7:2]};
  endfunction

  // Drive one cycle of inputs; pix_* carry the colour given LAT calls earlier.
  task automatic drive_cycle(input logic v, input logic s, input int x, input int y,
                             input logic [23:0] c);
    for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0]  = c;
    in_valid = v;
    in_sof   = s;
    in_x     = 10'(x);
    in_y     = 9'(y);
    {pix_r, pix_g, pix_b} = hist[LAT];
    case (ack_mode)
      0:       mem_ack = 1'b0;
      1:       mem_ack = 1'b1;
      default: mem_ack = ($urandom_range(3) != 0);
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 0, 0, 24'h0);
  endtask

  task automatic send_pair(input int x, input int y, input logic [23:0] c0,
                           input logic [23:0] c1, input bit expect_word, input bit sof);
    exp_t e;
    drive_cycle(1'b1, sof, x, y, c0);
    drive_cycle(1'b1, 1'b0, x + 1, y, c1);
    if (expect_word) begin
      e.addr = ADDR_W'(y * (FRAME_W / 2) + x / 2);
      e.data = {bpack(c0), bpack(c1)};
      sb.push_back(e);
    end
  endtask

  // Scoreboard: every accepted word is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_done) begin
        fd_cnt++;
        check_eq("fd_after_last", 64'(prev_last), 64'(1));
      end
      prev_last = 1'b0;
      if (mem_req && mem_ack) begin
        pop_cnt++;
        check_eq("pop_expected", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check_eq("addr", 64'(mem_addr), 64'(e.addr));
          check_eq("data", 64'(mem_data), 64'(e.data));
        end
        prev_last = (mem_addr == ADDR_W'(FRAME_H * FRAME_W / 2 - 1));
      end
    end else begin
      prev_last = 1'b0;
    end
  end

  initial begin
    logic [35:0] pair_data;
    pair_data = 36'hFE040007F;
    for (int i = 0; i <= LAT; i++) hist[i] = 24'h0;
    rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_x = '0; in_y = '0;
    pix_r = '0; pix_g = '0; pix_b = '0; mem_ack = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", 64'(mem_req), 64'(0));
    check_eq("rst_addr", 64'(mem_addr), 64'(0));
    check_eq("rst_data", 64'(mem_data), 64'(0));
    check_eq("rst_ovf", 64'(overflow), 64'(0));
    check_eq("rst_perr", 64'(pair_err), 64'(0));
    check_eq("rst_fd", 64'(frame_done), 64'(0));
    rst = 1'b1;
    idle(2);

    // Pair at (2,1), continuous ack: word lands at 1*320 + 1
    ack_mode = 1;
    send_pair(2, 1, 24'hFF8040, 24'h0004FC, 1'b1, 1'b0);
    idle(3);
    check_eq("lat_req_c4", 64'(mem_req), 64'(0));
    idle(1);
    check_eq("lat_req_c5", 64'(mem_req), 64'(1));
    check_eq("pair_addr", 64'(mem_addr), 64'(321));
    check_eq("pair_data", 64'(mem_data), 64'(pair_data));
    check_eq("pair_perr", 64'(pair_err), 64'(0));
    idle(4);

    // Back-pressure: 10 pairs, ack low; only the first 8 fit
    ack_mode = 0;
    for (int p = 0; p < 10; p++)
      send_pair(2 * p, 10, 24'($urandom), 24'($urandom), p < 8, 1'b0);
    idle(6);
    check_eq("bp_ovf", 64'(overflow), 64'(1));
    check_eq("bp_req", 64'(mem_req), 64'(1));
    pc0 = pop_cnt;
    ack_mode = 1;
    idle(14);
    check_eq("bp_pops", 64'(pop_cnt - pc0), 64'(8));
    check_eq("bp_sb_empty", 64'(sb.size()), 64'(0));
    check_eq("bp_req_low", 64'(mem_req), 64'(0));

    // Pairing faults: lone odd, then 6, 8, 9 -> one word for x=8
    drive_cycle(1'b1, 1'b0, 5, 20, 24'h123456);
    idle(4);
    check_eq("odd_alone_perr", 64'(pair_err), 64'(1));
    pc0 = pop_cnt;
    drive_cycle(1'b1, 1'b0, 6, 20, 24'hABCDEF);
    send_pair(8, 20, 24'h55AA33, 24'hC0FFEE, 1'b1, 1'b0);
    idle(8);
    check_eq("fault_pops", 64'(pop_cnt - pc0), 64'(1));
    check_eq("fault_sb_empty", 64'(sb.size()), 64'(0));

    // In-frame sof clears both sticky flags the cycle after it aligns
    check_eq("sof_pre_ovf", 64'(overflow), 64'(1));
    send_pair(0, 0, 24'h102030, 24'h405060, 1'b1, 1'b1);
    idle(2);
    check_eq("sof_c4_ovf", 64'(overflow), 64'(1));
    check_eq("sof_c4_perr", 64'(pair_err), 64'(1));
    idle(1);
    check_eq("sof_c5_ovf", 64'(overflow), 64'(0));
    check_eq("sof_c5_perr", 64'(pair_err), 64'(0));
    idle(6);

    // Full FIFO with a pop in the very cycle the 9th word is pushed
    ack_mode = 0;
    pc0 = pop_cnt;
    for (int p = 0; p < 9; p++)
      send_pair(2 * p, 30, 24'($urandom), 24'($urandom), 1'b1, 1'b0);
    idle(3);
    ack_mode = 1;
    idle(1);
    ack_mode = 0;
    idle(2);
    check_eq("full_pop_ovf", 64'(overflow), 64'(0));
    check_eq("full_pop_req", 64'(mem_req), 64'(1));
    check_eq("full_pop_one", 64'(pop_cnt - pc0), 64'(1));
    ack_mode = 1;
    idle(14);
    check_eq("full_pop_total", 64'(pop_cnt - pc0), 64'(9));
    check_eq("full_sb_empty", 64'(sb.size()), 64'(0));

    // Asynchronous reset while a word is stalled
    ack_mode = 0;
    send_pair(0, 40, 24'h777777, 24'h888888, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 3, 40, 24'h999999);
    idle(6);
    check_eq("pre_rst_req", 64'(mem_req), 64'(1));
    check_eq("pre_rst_perr", 64'(pair_err), 64'(1));
    #1 rst = 1'b0;
    #1;
    check_eq("arst_req", 64'(mem_req), 64'(0));
    check_eq("arst_addr", 64'(mem_addr), 64'(0));
    check_eq("arst_data", 64'(mem_data), 64'(0));
    check_eq("arst_perr", 64'(pair_err), 64'(0));
    check_eq("arst_ovf", 64'(overflow), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    ack_mode = 1;
    pc0 = pop_cnt;
    send_pair(10, 41, 24'h3C3C3C, 24'hC3C3C3, 1'b1, 1'b0);
    idle(8);
    check_eq("post_rst_pops", 64'(pop_cnt - pc0), 64'(1));

    // Tail of a full frame (last two lines) with random ack
    ack_mode = 2;
    pc0 = pop_cnt;
    check_eq("fd_none_yet", 64'(fd_cnt), 64'(0));
    for (int y = FRAME_H - 2; y < FRAME_H; y++) begin
      for (int x = 0; x < FRAME_W; x += 2) begin
        send_pair(x, y, 24'($urandom), 24'($urandom), 1'b1, (y == FRAME_H - 2) && (x == 0));
        idle(1);
      end
    end
    for (int i = 0; i < 500 && sb.size() != 0; i++) idle(1);
    check_eq("frame_drained", 64'(sb.size()), 64'(0));
    idle(3);
    check_eq("frame_pops", 64'(pop_cnt - pc0), 64'(FRAME_W));
    check_eq("frame_done_cnt", 64'(fd_cnt), 64'(1));
    check_eq("frame_ovf", 64'(overflow), 64'(0));
    check_eq("frame_perr", 64'(pair_err), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
